// File: rtl/modport_word_writer.sv
// Writer end of the modport word interface: a small FIFO feeding a registered
// output word with a valid/ready handshake, optionally bit-reversed for the readers.

module modport_word_writer_lane (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_d,
  output logic o_q
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)    o_q <= 1'b0;
    else if (i_load) o_q <= i_d;
endmodule

module modport_word_writer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 2,
  parameter int REVERSE = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic [WIDTH-1:0]           i_a,
  output logic                       o_ready,
  output logic [WIDTH-1:0]           o_x,
  output logic                       o_x_vld,
  input  logic                       i_x_rdy,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  // Async assert, two-flop synchronised release.
  logic [1:0] rst_pipe;
  logic       rst_n;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  assign rst_n = rst_pipe[1];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf, x_vld;
  state_t           state;
  logic [WIDTH-1:0] head;
  logic             fifo_nempty, push, pop;

  assign o_ready     = (count != CW'(DEPTH));
  assign fifo_nempty = (count != '0);
  assign head        = mem[rd_ptr];
  // Full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign push        = rst_n && !i_clr && i_en && o_ready;
  assign pop         = rst_n && !i_clr && fifo_nempty && (state == S_EMPTY || i_x_rdy);

  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= i_a;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      x_vld  <= 1'b0;
      state  <= S_EMPTY;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      x_vld  <= 1'b0;
      state  <= S_EMPTY;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (i_en && !o_ready) ovf <= 1'b1;
      case (state)
        S_EMPTY: if (fifo_nempty) begin
          state <= S_FULL;
          x_vld <= 1'b1;
        end
        S_FULL: if (i_x_rdy && !fifo_nempty) begin
          state <= S_EMPTY;
          x_vld <= 1'b0;
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  // One holding flop per reader lane; o_x keeps its value when not loading.
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    localparam int SRC = (REVERSE != 0) ? (WIDTH - 1 - k) : k;
    modport_word_writer_lane u_lane (
      .i_clk  (i_clk),
      .i_rst_n(rst_n),
      .i_load (pop),
      .i_d    (head[SRC]),
      .o_q    (o_x[k])
    );
  end

  assign o_x_vld = x_vld;
  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_ovf   = ovf;
endmodule

// File: tb/tb_modport_word_writer.sv
// Directed bench: scoreboard of accepted words, monitor checks each consumed o_x
// on both a reversing and a straight-copy instance.

module tb_modport_word_writer;
  localparam int W = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n, i_clr, i_en, i_x_rdy;
  logic [W-1:0] i_a;
  logic         o_ready, o_x_vld, o_empty, o_ovf;
  logic [W-1:0] o_x;
  logic [1:0]   o_count;
  logic         s_ready, s_x_vld, s_empty, s_ovf;
  logic [W-1:0] s_x;
  logic [1:0]   s_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] sb[$];

  always #5 i_clk = ~i_clk;

  modport_word_writer #(.WIDTH(W), .DEPTH(2), .REVERSE(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_en(i_en), .i_a(i_a),
    .o_ready(o_ready), .o_x(o_x), .o_x_vld(o_x_vld), .i_x_rdy(i_x_rdy),
    .o_count(o_count), .o_empty(o_empty), .o_ovf(o_ovf));

  modport_word_writer #(.WIDTH(W), .DEPTH(2), .REVERSE(0)) dut_s (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_en(i_en), .i_a(i_a),
    .o_ready(s_ready), .o_x(s_x), .o_x_vld(s_x_vld), .i_x_rdy(i_x_rdy),
    .o_count(s_count), .o_empty(s_empty), .o_ovf(s_ovf));

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    for (int k = 0; k < W; k++) rev[k] = v[W-1-k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic wr(input logic [W-1:0] a, input bit accept);
    i_en = 1'b1; i_a = a;
    if (accept) sb.push_back(a);
    cyc();
    i_en = 1'b0;
  endtask

  // Monitor: every word consumed by the readers must match the scoreboard head.
  always @(negedge i_clk) begin
    if (o_x_vld && i_x_rdy) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", o_x, $time);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        chk("mon_o_x_rev", o_x, rev(e));
        chk("mon_reader_o_a", rev(o_x), e);
        chk("mon_o_x_straight", s_x, e);
        chk("mon_straight_vld", s_x_vld, 1'b1);
      end
    end
  end

  initial begin
    i_rst_n = 1'b0; i_clr = 1'b0; i_en = 1'b0; i_x_rdy = 1'b0; i_a = '0;
    cyc(2);
    chk("rst_count", o_count, 0);
    chk("rst_vld",   o_x_vld, 0);
    chk("rst_ovf",   o_ovf,   0);
    chk("rst_ready", o_ready, 1);
    chk("rst_empty", o_empty, 1);
    chk("rst_o_x",   o_x,     0);
    i_rst_n = 1'b1;
    cyc(3);

    // 1: single word, latency 1, reversed
    i_x_rdy = 1'b1;
    wr(4'h1, 1);
    chk("t1_vld_not_yet", o_x_vld, 0);
    chk("t1_count", o_count, 1);
    cyc();
    chk("t1_vld", o_x_vld, 1);
    chk("t1_o_x", o_x, 4'h8);
    cyc();
    chk("t1_drained", o_x_vld, 0);

    // 2: fill with readers stalled, overflow, then drain
    i_x_rdy = 1'b0;
    wr(4'h3, 1);
    wr(4'h5, 1);
    wr(4'h9, 1);
    chk("t2_count", o_count, 2);
    chk("t2_ready", o_ready, 0);
    chk("t2_o_x", o_x, 4'hC);
    chk("t2_ovf_clear", o_ovf, 0);
    wr(4'hF, 0);
    chk("t2_ovf", o_ovf, 1);
    chk("t2_count_held", o_count, 2);
    chk("t2_o_x_held", o_x, 4'hC);
    i_x_rdy = 1'b1;
    cyc();
    chk("t2_o_x_a", o_x, 4'hA);
    cyc();
    chk("t2_o_x_9", o_x, 4'h9);
    cyc();
    chk("t2_done_vld", o_x_vld, 0);
    chk("t2_done_count", o_count, 0);
    chk("t2_o_x_kept", o_x, 4'h9);
    chk("t2_ovf_sticky", o_ovf, 1);

    // 3: streaming at one word per cycle
    for (int i = 0; i < 8; i++) begin
      wr(W'(i), 1);
      chk("t3_ready", o_ready, 1);
      chk("t3_count_le1", (o_count <= 1), 1);
    end
    cyc(2);
    chk("t3_done_vld", o_x_vld, 0);

    // 4: full FIFO, pop and push in the same cycle; push refused
    i_clr = 1'b1; cyc(); i_clr = 1'b0;
    chk("t4_ovf_cleared", o_ovf, 0);
    i_x_rdy = 1'b0;
    wr(4'h1, 1);
    wr(4'h2, 1);
    wr(4'h4, 1);
    chk("t4_full", o_count, 2);
    i_x_rdy = 1'b1;
    wr(4'h7, 0);
    chk("t4_ovf", o_ovf, 1);
    chk("t4_count", o_count, 1);
    chk("t4_o_x", o_x, 4'h4);
    cyc(2);
    chk("t4_done_vld", o_x_vld, 0);

    // 5: clear while full, with a concurrent write attempt
    i_x_rdy = 1'b0;
    wr(4'hB, 1);
    wr(4'h2, 1);
    wr(4'h4, 1);
    chk("t5_full", o_count, 2);
    chk("t5_vld", o_x_vld, 1);
    i_clr = 1'b1; i_en = 1'b1; i_a = 4'hE;
    cyc();
    i_clr = 1'b0; i_en = 1'b0;
    sb.delete();
    chk("t5_count", o_count, 0);
    chk("t5_vld_clr", o_x_vld, 0);
    chk("t5_ovf", o_ovf, 0);
    chk("t5_ready", o_ready, 1);
    chk("t5_o_x_kept", o_x, 4'hD);
    cyc();
    chk("t5_no_load", o_x_vld, 0);

    // 6: asynchronous reset mid-cycle
    wr(4'h3, 1);
    wr(4'h5, 1);
    #2 i_rst_n = 1'b0;
    #1;
    sb.delete();
    chk("t6_count", o_count, 0);
    chk("t6_vld",   o_x_vld, 0);
    chk("t6_ovf",   o_ovf,   0);
    chk("t6_ready", o_ready, 1);
    chk("t6_empty", o_empty, 1);
    chk("t6_o_x",   o_x,     0);
    chk("t6_s_o_x", s_x,     0);
    cyc();
    i_rst_n = 1'b1;
    cyc(3);
    i_x_rdy = 1'b1;
    wr(4'h6, 1);
    chk("t6_lat_vld0", o_x_vld, 0);
    cyc();
    chk("t6_vld", o_x_vld, 1);
    chk("t6_o_x_rev", o_x, 4'h6);
    chk("t6_s_o_x_6", s_x, 4'h6);
    wr(4'h2, 1);
    chk("t6_o_x_2", o_x, 4'h6);
    cyc();
    chk("t6_o_x_4", o_x, 4'h4);
    chk("t6_s_o_x_2", s_x, 4'h2);
    cyc(2);
    chk("end_sb_empty", sb.size(), 0);
    chk("end_vld", o_x_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/modport_word_writer.md
Name: modport_word_writer

Overview:
- Writer end of the 4-bit modport word interface, feeding the per-bit reader submodules that flop `x[k]` onto `o_a[WIDTH-1-k]`.
- Replaces the enable-gated latch capture with a fully flop-based path: a small FIFO, then an output holding register with a valid/ready handshake.
- When `REVERSE=1`, words are pre-reversed so that the reader side reconstructs the original bit order at its outputs.

Parameters:
- WIDTH, 4: data word width, also the number of reader lanes.
- DEPTH, 2: FIFO entries; power of two, minimum 2.
- REVERSE, 1: 1 = `o_x[k]` takes `entry[WIDTH-1-k]`; 0 = straight copy.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_clr  input  1  synchronous flush.
- i_en  input  1  write request; word accepted when `i_en && o_ready`.
- i_a  input  WIDTH  write data.
- o_ready  output  1  FIFO not full.
- o_x  output  WIDTH  interface data word to readers.
- o_x_vld  output  1  `o_x` holds a valid word.
- i_x_rdy  input  1  readers consume `o_x` this cycle.
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy, excluding the output register.
- o_empty  output  1  `o_count == 0`.
- o_ovf  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (`i_rst_n` low, asynchronous, any cycle):
  - FIFO pointers and `o_count` go to 0.
  - `o_x = 0`, `o_x_vld = 0`, `o_ovf = 0`, `o_ready = 1`, `o_empty = 1`.
  - Deassertion is synchronised internally with a 2-flop chain; state stays in reset until the chain releases.
- Push: `i_en && o_ready` writes `i_a` at the write pointer; the pointer wraps modulo DEPTH.
- `o_ready = (o_count != DEPTH)`, purely combinational from registered count.
- When full, no push occurs even if a pop happens in the same cycle (no pass-through while full).
- Overflow: `i_en && !o_ready` sets `o_ovf`. The dropped word is discarded and FIFO contents are unchanged.
- Output register, two states:
  - EMPTY (`o_x_vld = 0`): if FIFO is non-empty, pop the head, load `o_x`, go to FULL.
  - FULL (`o_x_vld = 1`): `o_x` is held stable while `!i_x_rdy`.
    - If `i_x_rdy` and FIFO non-empty: pop and reload `o_x` (back-to-back, one word per cycle), stay in FULL.
    - If `i_x_rdy` and FIFO empty: `o_x_vld` goes to 0, `o_x` keeps its last value, go to EMPTY.
- Latency: a word accepted at edge N appears as `o_x`/`o_x_vld` at edge N+1 when the output is EMPTY. There is no combinational bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Load mapping:
  - REVERSE=1: `o_x[k] = head[WIDTH-1-k]`, so readers produce `o_a == i_a`.
  - REVERSE=0: `o_x = head`.
- `i_x_rdy` while `o_x_vld = 0` is ignored.
- `i_clr` (priority over push, pop and load):
  - Pointers and count go to 0, `o_x_vld = 0`, `o_ovf = 0`.
  - `o_x` value is retained.
  - A concurrent `i_en` is dropped and does not set `o_ovf`.
- `o_count` range is 0..DEPTH. Throughput is 1 word/cycle sustained when `i_x_rdy` is held at 1.

Test Plan:
1. Reset, then `i_en=1, i_a=4'b0001` for one cycle, `i_x_rdy=1`:
   - `o_x_vld` is 1 one cycle later with `o_x=4'b1000`.
   - Through the reader stage, `o_a=4'b0001`.
2. `i_x_rdy=0`, write 0x3, 0x5, 0x9:
   - 0x3 moves to `o_x`; 0x5 and 0x9 fill the FIFO (`o_count=2`, `o_ready=0`).
   - A 4th write 0xF is dropped and sets `o_ovf=1`.
   - Raising `i_x_rdy` drains reversed 0x3, 0x5, 0x9 (`o_x` = 0xC, 0xA, 0x9) on consecutive cycles; 0xF never appears.
3. `i_x_rdy=1`, continuous writes 0..7:
   - One word per cycle, in order, `o_ready` never drops.
   - `o_count` stays ≤1.
4. FIFO full, `i_x_rdy=1` and `i_en=1` in the same cycle:
   - Pop occurs, push is refused.
   - `o_ovf` set, `o_count` drops to 1.
5. Assert `i_clr` with `o_count=2`, `o_x_vld=1` and `i_en=1`:
   - Next cycle: `o_count=0`, `o_x_vld=0`, `o_ovf=0`, `o_ready=1`.
6. `i_rst_n` pulsed low mid-stream, asynchronously between edges:
   - All outputs reach reset values immediately.
   - First post-release write appears with latency 1 and correct reversal.
   - With REVERSE=0, `i_a=0x6` gives `o_x=0x6`.
